// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs the inhibit / request-to-send handshake, shifts one byte plus odd
// parity and stop bit on device clock falling edges, then checks the ack.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INHIBIT = 3'd1,
      S_REQ     = 3'd2,
      S_XFER    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t           r_state;
   logic [7:0]       r_byte;
   logic             r_parity;
   logic [INH_W-1:0] r_inh_cnt;
   logic [TO_W-1:0]  r_to_cnt;
   logic [3:0]       r_edge_cnt;
   logic             r_tx_ready;
   logic             r_tx_done;
   logic             r_tx_error;
   logic             r_clk_oe;
   logic             r_data_oe;

   logic             r_clk_s1;
   logic             r_clk_s2;
   logic             r_clk_hist;
   logic             r_data_s1;
   logic             r_data_s2;

   logic             w_clk_fe;
   logic [3:0]       w_edge_next;
   logic [2:0]       w_bit_idx;

   assign w_clk_fe    = r_clk_hist & ~r_clk_s2;
   assign w_edge_next = r_edge_cnt + 4'd1;
   assign w_bit_idx   = 3'(r_edge_cnt);

   assign tx_ready    = r_tx_ready;
   assign tx_done     = r_tx_done;
   assign tx_error    = r_tx_error;
   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;

   // Synchronize the PS/2 pins and keep a clock history flop for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_hist <= 1'b1;
         r_data_s1  <= 1'b1;
         r_data_s2  <= 1'b1;
      end else begin
         r_clk_s1   <= ps2_clk_in;
         r_clk_s2   <= r_clk_s1;
         r_clk_hist <= r_clk_s2;
         r_data_s1  <= ps2_data_in;
         r_data_s2  <= r_data_s1;
      end
   end

   // Transfer sequencer with registered bus enables and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_byte     <= 8'h00;
         r_parity   <= 1'b0;
         r_inh_cnt  <= '0;
         r_to_cnt   <= '0;
         r_edge_cnt <= 4'd0;
         r_tx_ready <= 1'b1;
         r_tx_done  <= 1'b0;
         r_tx_error <= 1'b0;
         r_clk_oe   <= 1'b0;
         r_data_oe  <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tx_valid) begin
                  r_byte     <= tx_data;
                  r_parity   <= ~^tx_data;
                  r_inh_cnt  <= '0;
                  r_tx_ready <= 1'b0;
                  r_clk_oe   <= 1'b1;
                  r_data_oe  <= 1'b0;
                  r_state    <= S_INHIBIT;
               end
            end

            S_INHIBIT: begin
               if (r_inh_cnt == INH_LAST) begin
                  r_data_oe <= 1'b1;
                  r_state   <= S_REQ;
               end else begin
                  r_inh_cnt <= r_inh_cnt + INH_W'(1);
               end
            end

            S_REQ: begin
               r_clk_oe   <= 1'b0;
               r_to_cnt   <= '0;
               r_edge_cnt <= 4'd0;
               r_state    <= S_XFER;
            end

            S_XFER: begin
               // A device edge takes priority over a coincident timeout
               if (w_clk_fe) begin
                  r_to_cnt   <= '0;
                  r_edge_cnt <= w_edge_next;
                  case (w_edge_next)
                     4'd9:    r_data_oe <= ~r_parity;
                     4'd10:   r_data_oe <= 1'b0;
                     4'd11: begin
                        r_data_oe  <= 1'b0;
                        r_tx_error <= r_data_s2;
                        r_tx_done  <= 1'b1;
                        r_state    <= S_DONE;
                     end
                     default: r_data_oe <= ~r_byte[w_bit_idx];
                  endcase
               end else if (r_to_cnt == TO_LIMIT) begin
                  r_clk_oe   <= 1'b0;
                  r_data_oe  <= 1'b0;
                  r_tx_error <= 1'b1;
                  r_tx_done  <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end

            S_DONE: begin
               r_clk_oe   <= 1'b0;
               r_data_oe  <= 1'b0;
               r_tx_ready <= 1'b1;
               r_state    <= S_IDLE;
            end

            default: begin
               r_clk_oe   <= 1'b0;
               r_data_oe  <= 1'b0;
               r_tx_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with an open-collector bus and a
// behavioural PS/2 device that clocks frames in and optionally acks.
module tb_ps2_host_tx;

   localparam int unsigned INH = 10;
   localparam int unsigned TMO = 200;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;

   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;

   // Wired-AND open-collector lines
   assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
   assign ps2_data_in = ~ps2_data_oe & dev_data;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observers for done pulses and the bus-enable timing
   int         done_cnt = 0;
   int         done_cyc = 0;
   logic       done_err = 1'b0;
   logic [1:0] done_oe  = 2'b00;
   logic       prev_done = 1'b0;
   logic       done_wide = 1'b0;
   logic       ready_after = 1'b0;
   logic       prev_coe = 1'b0;
   logic       prev_doe = 1'b0;
   int         run = 0;
   int         last_run = 0;
   int         clk_rise_cyc = 0;
   int         clk_fall_cyc = 0;
   int         data_rise_cyc = 0;

   always @(negedge clk) begin
      prev_done <= tx_done;
      if (tx_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
         done_err <= tx_error;
         done_oe  <= {ps2_clk_oe, ps2_data_oe};
         if (prev_done) done_wide <= 1'b1;
      end
      if (prev_done) ready_after <= tx_ready;
      prev_coe <= ps2_clk_oe;
      prev_doe <= ps2_data_oe;
      if (ps2_clk_oe) begin
         if (!prev_coe) clk_rise_cyc <= cyc;
         run <= run + 1;
      end else begin
         if (prev_coe) begin
            clk_fall_cyc <= cyc;
            last_run     <= run;
         end
         run <= 0;
      end
      if (ps2_data_oe && !prev_doe && ps2_clk_oe) data_rise_cyc <= cyc;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: start 0, data LSB first, odd parity, stop 1
   function automatic logic [10:0] ref_frame(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         ones += int'(d[i]);
         f[i+1] = d[i];
      end
      f[0]  = 1'b0;
      f[9]  = ((ones % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      acc_cyc  = cyc;
      tx_valid = 1'b0;
   endtask

   // Device: waits for request-to-send, then 11 clocks of 40 cycles
   task automatic device(input bit ack, input int abort_k,
                         output logic [10:0] frame, output bit ok);
      int t;
      ok = 1'b0;
      frame = '0;
      t = 0;
      while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) return;
      repeat (10) @(negedge clk);
      frame[0] = ps2_data_in;
      for (int k = 1; k <= 11; k++) begin
         dev_clk = 1'b0;
         if (k == abort_k) begin
            repeat (8) @(negedge clk);
            dev_clk = 1'b1;
            ok = 1'b1;
            return;
         end
         repeat (20) @(negedge clk);
         dev_clk = 1'b1;
         if (k <= 10) frame[k] = ps2_data_in;
         if (k == 10 && ack) dev_data = 1'b0;
         repeat (20) @(negedge clk);
      end
      dev_data = 1'b1;
      ok = 1'b1;
   endtask

   task automatic do_xfer(input logic [7:0] d, input bit ack, input bit exp_err,
                          input bit inject, input string tag,
                          output logic [10:0] frame);
      int d0;
      int t;
      bit ok;
      logic [10:0] exp_f;
      d0 = done_cnt;
      fork
         send(d);
         device(ack, 0, frame, ok);
         begin
            if (inject) begin
               repeat (150) @(negedge clk);
               check({tag, " ready_busy"}, int'(tx_ready), 0);
               tx_data  = 8'hAA;
               tx_valid = 1'b1;
               @(negedge clk);
               tx_valid = 1'b0;
               tx_data  = 8'h00;
            end
         end
      join
      check({tag, " device_ok"}, int'(ok), 1);
      t = 0;
      while (done_cnt == d0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      exp_f = ref_frame(d);
      check({tag, " done_count"}, done_cnt - d0, 1);
      check({tag, " error"}, int'(done_err), int'(exp_err));
      check({tag, " oe_at_done"}, int'(done_oe), 0);
      check({tag, " ready_after"}, int'(ready_after), 1);
      check({tag, " frame"}, int'(frame), int'(exp_f));
      repeat (30) @(negedge clk);
      check({tag, " error_held"}, int'(tx_error), int'(exp_err));
      check({tag, " idle_after"}, int'({tx_ready, ps2_clk_oe}), 2);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         exp_err;
      bit         exp_par;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [10:0] fr;
      int d0;
      int t;
      logic [7:0] rd;
      bit rack;
      bit ok;

      vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            int'({tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}), 5'b10000);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Table-driven transfers
      for (int i = 0; i < 5; i++) begin
         do_xfer(vecs[i].data, vecs[i].ack, vecs[i].exp_err, 1'b0,
                 $sformatf("vec%0d", i), fr);
         check($sformatf("vec%0d parity", i), int'(fr[9]), int'(vecs[i].exp_par));
         if (i == 0) begin
            check("clk_oe_run", last_run, INH + 1);
            check("clk_oe_rise", clk_rise_cyc, acc_cyc);
            check("data_rise_before_fall", data_rise_cyc, clk_fall_cyc - 1);
            check("ed_frame", int'(fr), int'(11'b11_1110_1101_0));
         end
      end

      // Randomized transfers against the reference frame model
      for (int i = 0; i < 4; i++) begin
         rd   = 8'($urandom);
         rack = 1'($urandom_range(0, 1));
         do_xfer(rd, rack, ~rack, 1'b0, $sformatf("rnd%0d", i), fr);
      end

      // tx_valid with 0xAA mid-transfer is ignored
      do_xfer(8'h3C, 1'b1, 1'b0, 1'b1, "inject", fr);

      // Silent device: timeout
      d0 = done_cnt;
      send(8'h5A);
      t = 0;
      while (done_cnt == d0 && t < 600) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      check("timeout done_count", done_cnt - d0, 1);
      check("timeout latency", done_cyc - clk_fall_cyc, TMO + 1);
      check("timeout error", int'(done_err), 1);
      check("timeout oe", int'(done_oe), 0);
      repeat (5) @(negedge clk);

      // Reset at edge 5 releases the bus immediately, no done pulse
      d0 = done_cnt;
      fork
         send(8'h0F);
         device(1'b1, 5, fr, ok);
      join
      check("abort device_ok", int'(ok), 1);
      check("abort pre_reset data_oe", int'(ps2_data_oe), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort oe_async", int'({ps2_clk_oe, ps2_data_oe}), 0);
      check("abort ready_async", int'(tx_ready), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("abort no_done", done_cnt - d0, 0);
      check("abort ready_after", int'(tx_ready), 1);
      check("abort error_cleared", int'(tx_error), 0);

      check("done_single_cycle", int'(done_wide), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
